// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//
// Issue/capture stage wrapped around an external combinational ALU.
// A command (opcode + two operands) is accepted over a valid/ready
// handshake and registered onto the ALU inputs. After SETTLE extra
// cycles the ALU result and flags are captured into a response register
// that is offered downstream over valid/ready. A completed-operation
// counter and a sticky overflow flag are kept alongside.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_opcode/a/b       command fields, sampled only on acceptance
//   alu_a/b/opcode       registered operands and opcode driving the ALU
//   alu_result/flags     combinational ALU outputs (carry, overflow, zero)
//   rsp_valid/rsp_ready  response handshake; rsp_valid is high only in RESP
//   rsp_result/flags     captured ALU result and flags
//   op_count             number of consumed responses, wraps modulo 2^NUMBITS
//   ovf_sticky           set by any captured overflow
//   clr_sticky           synchronous clear of ovf_sticky (a new set wins)

module alu_seq_ctrl #(
   parameter int NUMBITS = 16,
   parameter int SETTLE  = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_opcode,
   input  logic [NUMBITS-1:0] cmd_a,
   input  logic [NUMBITS-1:0] cmd_b,
   output logic [NUMBITS-1:0] alu_a,
   output logic [NUMBITS-1:0] alu_b,
   output logic [2:0]         alu_opcode,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_carryout,
   input  logic               alu_overflow,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [NUMBITS-1:0] rsp_result,
   output logic               rsp_carryout,
   output logic               rsp_overflow,
   output logic               rsp_zero,
   output logic [NUMBITS-1:0] op_count,
   output logic               ovf_sticky,
   input  logic               clr_sticky
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   logic [1:0]         state_q, state_d;
   logic [3:0]         settle_q, settle_d;
   logic [NUMBITS-1:0] aluA_q, aluA_d;
   logic [NUMBITS-1:0] aluB_q, aluB_d;
   logic [2:0]         aluOp_q, aluOp_d;
   logic [NUMBITS-1:0] rspResult_q, rspResult_d;
   logic               rspCarry_q, rspCarry_d;
   logic               rspOvf_q, rspOvf_d;
   logic               rspZero_q, rspZero_d;
   logic [NUMBITS-1:0] opCount_q, opCount_d;
   logic               sticky_q, sticky_d;
   logic               capture;

   // Next-state logic. Command fields are only looked at when cmd_valid
   // is high in IDLE, so junk on an idle bus never reaches a register.
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      aluOp_d     = aluOp_q;
      rspResult_d = rspResult_q;
      rspCarry_d  = rspCarry_q;
      rspOvf_d    = rspOvf_q;
      rspZero_d   = rspZero_q;
      opCount_d   = opCount_q;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               aluA_d   = cmd_a;
               aluB_d   = cmd_b;
               aluOp_d  = cmd_opcode;
               settle_d = SETTLE_CNT;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (settle_q == 4'd0) begin
               capture     = 1'b1;
               rspResult_d = alu_result;
               rspCarry_d  = alu_carryout;
               rspOvf_d    = alu_overflow;
               rspZero_d   = alu_zero;
               state_d     = RESP;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               opCount_d = opCount_q + NUMBITS'(1);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear first so that an overflow captured on the same edge wins.
      sticky_d = sticky_q;
      if (clr_sticky) begin
         sticky_d = 1'b0;
      end
      if (capture && alu_overflow) begin
         sticky_d = 1'b1;
      end
   end

   // Reset throws away any in-flight command along with all held state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         settle_q    <= 4'd0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         aluOp_q     <= 3'd0;
         rspResult_q <= '0;
         rspCarry_q  <= 1'b0;
         rspOvf_q    <= 1'b0;
         rspZero_q   <= 1'b0;
         opCount_q   <= '0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         aluOp_q     <= aluOp_d;
         rspResult_q <= rspResult_d;
         rspCarry_q  <= rspCarry_d;
         rspOvf_q    <= rspOvf_d;
         rspZero_q   <= rspZero_d;
         opCount_q   <= opCount_d;
         sticky_q    <= sticky_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == RESP);
   assign alu_a        = aluA_q;
   assign alu_b        = aluB_q;
   assign alu_opcode   = aluOp_q;
   assign rsp_result   = rspResult_q;
   assign rsp_carryout = rspCarry_q;
   assign rsp_overflow = rspOvf_q;
   assign rsp_zero     = rspZero_q;
   assign op_count     = opCount_q;
   assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//
// Bench for alu_seq_ctrl. A 16-bit instance with SETTLE=0 is driven by
// directed and random commands; expected responses are pushed into a
// queue on issue and a negedge monitor pops and compares them. An 8-bit
// instance with SETTLE=3 covers settle latency, throughput, counter wrap
// and asynchronous reset in the middle of an operation.

module tb_alu_seq_ctrl;

   localparam int NB      = 16;
   localparam int NB2     = 8;
   localparam int SETTLE0 = 0;
   localparam int SETTLE2 = 3;

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        v;
      logic        z;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   int compared   = 0;
   int mismatched = 0;

   // Main instance signals
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_opcode;
   logic [NB-1:0] cmd_a, cmd_b;
   logic [NB-1:0] alu_a, alu_b, alu_result;
   logic [2:0]    alu_opcode;
   logic          alu_carryout, alu_overflow, alu_zero;
   logic          rsp_valid, rsp_ready;
   logic [NB-1:0] rsp_result;
   logic          rsp_carryout, rsp_overflow, rsp_zero;
   logic [NB-1:0] op_count;
   logic          ovf_sticky, clr_sticky;

   // Second instance signals
   logic           reset2;
   logic           cmd2_valid, cmd2_ready;
   logic [2:0]     cmd2_opcode;
   logic [NB2-1:0] cmd2_a, cmd2_b;
   logic [NB2-1:0] alu2_a, alu2_b, alu2_result;
   logic [2:0]     alu2_opcode;
   logic           rsp2_valid, rsp2_ready;
   logic [NB2-1:0] rsp2_result;
   logic           rsp2_carryout, rsp2_overflow, rsp2_zero;
   logic [NB2-1:0] op_count2;
   logic           ovf2_sticky;

   // Reference ALU written with plain integer arithmetic.
   function automatic rsp_t aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      rsp_t r;
      int   ua, ub, sa, sb, sum;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = '0;
      case (op)
         3'd0: begin sum = ua + ub; r.res = 16'(sum); r.c = (sum > 65535); end
         3'd1: begin
            sum = sa + sb; r.res = 16'(sum); r.c = ((ua + ub) > 65535);
            r.v = (sum > 32767) || (sum < -32768);
         end
         3'd2: begin sum = ua - ub; r.res = 16'(sum); r.c = (ua < ub); end
         3'd3: begin
            sum = sa - sb; r.res = 16'(sum); r.c = (ua < ub);
            r.v = (sum > 32767) || (sum < -32768);
         end
         3'd4: r.res = a & b;
         3'd5: r.res = a | b;
         3'd6: r.res = a ^ b;
         default: r.res = 16'(sa >>> 1);
      endcase
      r.z = (r.res == 16'd0);
      return r;
   endfunction

   rsp_t aluOut;
   assign aluOut       = aluRef(alu_opcode, alu_a, alu_b);
   assign alu_result   = aluOut.res;
   assign alu_carryout = aluOut.c;
   assign alu_overflow = aluOut.v;
   assign alu_zero     = aluOut.z;

   // The narrow instance only needs an xor ALU for its tests.
   assign alu2_result = alu2_a ^ alu2_b;

   alu_seq_ctrl #(.NUMBITS(NB), .SETTLE(SETTLE0)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carryout(alu_carryout),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .op_count(op_count), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
   );

   alu_seq_ctrl #(.NUMBITS(NB2), .SETTLE(SETTLE2)) dut2 (
      .clk(clk), .reset(reset2),
      .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready), .cmd_opcode(cmd2_opcode),
      .cmd_a(cmd2_a), .cmd_b(cmd2_b),
      .alu_a(alu2_a), .alu_b(alu2_b), .alu_opcode(alu2_opcode),
      .alu_result(alu2_result), .alu_carryout(1'b0),
      .alu_overflow(1'b0), .alu_zero(alu2_result == '0),
      .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_result(rsp2_result),
      .rsp_carryout(rsp2_carryout), .rsp_overflow(rsp2_overflow), .rsp_zero(rsp2_zero),
      .op_count(op_count2), .ovf_sticky(ovf2_sticky), .clr_sticky(1'b0)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard and model state
   rsp_t        expQ[$];
   bit          monEn        = 1'b0;
   bit          busyModel    = 1'b0;
   bit          prevRspValid = 1'b0;
   bit          prevClr      = 1'b0;
   bit          stickyModel  = 1'b0;
   logic [15:0] countModel   = 16'd0;
   int          acceptCycle  = 0;

   // 0: random, 1: always high, 2: held low
   int rspMode = 1;
   // 0: low, 1: occasional random pulse, 2: held high
   int clrMode = 0;

   initial begin
      rsp_ready  = 1'b0;
      clr_sticky = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rspMode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
         endcase
         case (clrMode)
            1:       clr_sticky = ($urandom_range(0, 15) == 0);
            2:       clr_sticky = 1'b1;
            default: clr_sticky = 1'b0;
         endcase
      end
   end

   // Monitor: all values sampled at negedge apply to the following posedge.
   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("cmd_ready", 32'(cmd_ready), 32'(!busyModel));
         if (rsp_valid && !prevRspValid) begin
            checkOutput("latency", 32'(cycle - acceptCycle), 32'(SETTLE0 + 1));
            if (expQ.size() == 0) begin
               checkOutput("spurious_capture", 32'(1), 32'(0));
            end else if (expQ[0].v) begin
               stickyModel = 1'b1;
            end else if (prevClr) begin
               stickyModel = 1'b0;
            end
         end else if (prevClr) begin
            stickyModel = 1'b0;
         end
         checkOutput("ovf_sticky", 32'(ovf_sticky), 32'(stickyModel));
         checkOutput("op_count", 32'(op_count), 32'(countModel));
         if (rsp_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_rsp", 32'(1), 32'(0));
            end else begin
               checkOutput("rsp_result", 32'(rsp_result), 32'(expQ[0].res));
               checkOutput("rsp_carryout", 32'(rsp_carryout), 32'(expQ[0].c));
               checkOutput("rsp_overflow", 32'(rsp_overflow), 32'(expQ[0].v));
               checkOutput("rsp_zero", 32'(rsp_zero), 32'(expQ[0].z));
               if (rsp_ready) begin
                  void'(expQ.pop_front());
                  countModel = countModel + 16'd1;
                  busyModel  = 1'b0;
               end
            end
         end
         if (cmd_valid && cmd_ready) begin
            busyModel   = 1'b1;
            acceptCycle = cycle + 1;
         end
         prevRspValid = rsp_valid;
         prevClr      = clr_sticky;
      end
   end

   // Presents a command until accepted and pushes its expected response.
   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int guard;
      guard      = 0;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_valid  = 1'b1;
      @(negedge clk);
      while (!cmd_ready && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         checkOutput("accept_timeout", 32'(0), 32'(1));
      end else begin
         expQ.push_back(aluRef(op, a, b));
      end
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      cmd_opcode = 3'($urandom());
      cmd_a      = 16'($urandom());
      cmd_b      = 16'($urandom());
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while ((expQ.size() != 0 || busyModel) && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      checkOutput("drain", 32'(expQ.size()), 32'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus2(input logic [7:0] a, input logic [7:0] b, output int acc);
      int guard;
      guard       = 0;
      acc         = 0;
      cmd2_opcode = 3'd6;
      cmd2_a      = a;
      cmd2_b      = b;
      cmd2_valid  = 1'b1;
      @(negedge clk);
      while (!cmd2_ready && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      if (!cmd2_ready) begin
         checkOutput("accept2_timeout", 32'(0), 32'(1));
      end
      acc = cycle + 1;
      @(posedge clk);
      #1;
      cmd2_valid = 1'b0;
      cmd2_a     = 8'($urandom());
   endtask

   function automatic logic [15:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return 16'($urandom());
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc0, acc1, cnt2Model;
      reset       = 1'b0;
      reset2      = 1'b0;
      cmd_valid   = 1'b0;
      cmd_opcode  = 3'd0;
      cmd_a       = 16'd0;
      cmd_b       = 16'd0;
      cmd2_valid  = 1'b0;
      cmd2_opcode = 3'd0;
      cmd2_a      = 8'd0;
      cmd2_b      = 8'd0;
      rsp2_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      checkOutput("reset_alu_a", 32'(alu_a), 32'(0));
      checkOutput("reset_alu_opcode", 32'(alu_opcode), 32'(0));
      checkOutput("reset_rsp_result", 32'(rsp_result), 32'(0));
      checkOutput("reset_op_count", 32'(op_count), 32'(0));
      checkOutput("reset_ovf_sticky", 32'(ovf_sticky), 32'(0));
      @(posedge clk);
      #1;
      reset  = 1'b1;
      reset2 = 1'b1;
      monEn  = 1'b1;

      // Directed: carry/zero, then signed overflow with clear held high.
      rspMode = 1;
      applyStimulus(3'd0, 16'hFFFF, 16'h0001);
      applyStimulus(3'd1, 16'h7FFF, 16'h0001);
      waitDrain();
      clrMode = 2;
      applyStimulus(3'd1, 16'h7FFF, 16'h0001);
      waitDrain();
      clrMode = 0;
      repeat (2) @(posedge clk);
      #1;
      clrMode = 2;
      @(posedge clk);
      #1;
      clrMode = 0;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure while a second command waits.
      rspMode = 2;
      applyStimulus(3'd6, 16'h00FF, 16'h0F0F);
      fork
         applyStimulus(3'd2, 16'h0001, 16'h0002);
         begin
            repeat (6) @(posedge clk);
            #1;
            rspMode = 1;
         end
      join
      waitDrain();

      // Random traffic with random backpressure and sticky clears.
      rspMode = 0;
      clrMode = 1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
      end
      rspMode = 1;
      waitDrain();
      clrMode = 0;

      // Narrow instance, SETTLE=3: latency and stable ALU inputs.
      @(posedge clk);
      #1;
      cmd2_valid  = 1'b1;
      cmd2_opcode = 3'd6;
      cmd2_a      = 8'h3C;
      cmd2_b      = 8'h0F;
      @(negedge clk);
      checkOutput("s3_cmd_ready_idle", 32'(cmd2_ready), 32'(1));
      @(posedge clk);
      #1;
      cmd2_valid = 1'b0;
      cmd2_a     = 8'hAA;
      cmd2_b     = 8'h55;
      for (int k = 0; k < SETTLE2 + 1; k++) begin
         @(negedge clk);
         checkOutput("s3_rsp_valid_low", 32'(rsp2_valid), 32'(0));
         checkOutput("s3_cmd_ready_busy", 32'(cmd2_ready), 32'(0));
         checkOutput("s3_alu_a", 32'(alu2_a), 32'(8'h3C));
         checkOutput("s3_alu_b", 32'(alu2_b), 32'(8'h0F));
         checkOutput("s3_alu_opcode", 32'(alu2_opcode), 32'(3'd6));
      end
      @(negedge clk);
      checkOutput("s3_rsp_valid_high", 32'(rsp2_valid), 32'(1));
      checkOutput("s3_rsp_result", 32'(rsp2_result), 32'(8'h33));
      @(posedge clk);
      #1;
      rsp2_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      cnt2Model = 1;
      checkOutput("s3_op_count", 32'(op_count2), 32'(cnt2Model));
      checkOutput("s3_rsp_valid_after", 32'(rsp2_valid), 32'(0));
      checkOutput("s3_rsp_result_held", 32'(rsp2_result), 32'(8'h33));

      // Throughput and op_count wrap on the narrow instance.
      @(posedge clk);
      #1;
      applyStimulus2(8'h01, 8'h02, acc0);
      applyStimulus2(8'h05, 8'h06, acc1);
      checkOutput("s3_throughput", 32'(acc1 - acc0), 32'(SETTLE2 + 3));
      cnt2Model = cnt2Model + 2;
      for (int i = 0; i < 253; i++) begin
         applyStimulus2(8'($urandom_range(1, 255)), 8'h00, acc0);
         cnt2Model++;
      end
      repeat (SETTLE2 + 4) @(posedge clk);
      @(negedge clk);
      checkOutput("s3_op_count_wrap", 32'(op_count2), 32'(cnt2Model % 256));

      // Asynchronous reset in the middle of EXEC.
      rsp2_ready = 1'b0;
      @(posedge clk);
      #1;
      cmd2_valid  = 1'b1;
      cmd2_a      = 8'h05;
      cmd2_b      = 8'h03;
      @(posedge clk);
      #1;
      cmd2_valid = 1'b0;
      @(posedge clk);
      #2;
      reset2 = 1'b0;
      #1;
      checkOutput("rst_rsp_valid", 32'(rsp2_valid), 32'(0));
      checkOutput("rst_alu_a", 32'(alu2_a), 32'(0));
      checkOutput("rst_alu_b", 32'(alu2_b), 32'(0));
      checkOutput("rst_alu_opcode", 32'(alu2_opcode), 32'(0));
      checkOutput("rst_rsp_result", 32'(rsp2_result), 32'(0));
      checkOutput("rst_op_count", 32'(op_count2), 32'(0));
      @(posedge clk);
      #1;
      reset2     = 1'b1;
      rsp2_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("post_rst_rsp_valid", 32'(rsp2_valid), 32'(0));
         checkOutput("post_rst_cmd_ready", 32'(cmd2_ready), 32'(1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Issue/capture stage wrapped around the combinational ALU (NUMBITS-wide; opcodes 000 add unsigned, 001 add signed, 010 sub unsigned, 011 sub signed, 100 and, 101 or, 110 xor, 111 arithmetic shift right by 1).
- Accepts commands over a valid/ready handshake and registers operands and opcode to drive the ALU.
- Waits a parameterised settle time, then captures result and flags into a response register presented downstream over valid/ready.
- Also keeps a completed-operation counter and a sticky overflow flag.

Parameters:
NUMBITS  16  operand/result width; must match the ALU
SETTLE   0   extra EXEC cycles before capture; range 0..15

Ports:
clk            input   1            rising-edge clock
reset          input   1            asynchronous, active-low reset (asserted when 0)
cmd_valid      input   1            command present
cmd_ready      output  1            stage can accept a command
cmd_opcode     input   3            ALU opcode
cmd_a          input   NUMBITS      operand A
cmd_b          input   NUMBITS      operand B
alu_a          output  NUMBITS      registered operand A to ALU
alu_b          output  NUMBITS      registered operand B to ALU
alu_opcode     output  3            registered opcode to ALU
alu_result     input   NUMBITS      ALU result
alu_carryout   input   1            ALU carry/borrow flag
alu_overflow   input   1            ALU signed overflow flag
alu_zero       input   1            ALU zero flag
rsp_valid      output  1            response present
rsp_ready      input   1            downstream accepts response
rsp_result     output  NUMBITS      captured result
rsp_carryout   output  1            captured carry
rsp_overflow   output  1            captured overflow
rsp_zero       output  1            captured zero
op_count       output  NUMBITS      responses consumed, wraps modulo 2^NUMBITS
ovf_sticky     output  1            set by any captured overflow
clr_sticky     input   1            synchronous clear of ovf_sticky

Behaviour:
- Reset (reset==0, async):
  - FSM goes to IDLE.
  - alu_a, alu_b, alu_opcode, all rsp_* outputs, op_count, ovf_sticky and the settle counter all go to 0.
  - cmd_ready reads 1 once reset is released.
  - Reset mid-operation discards the in-flight command; no response is produced.
- FSM states: IDLE, EXEC, RESP. Outputs cmd_ready and rsp_valid are Moore: cmd_ready = (state==IDLE), rsp_valid = (state==RESP).
- IDLE:
  - On cmd_valid at an edge: load alu_a/alu_b/alu_opcode from cmd_*, load settle counter = SETTLE, go to EXEC.
  - Otherwise hold; ALU inputs keep the last command.
- EXEC:
  - If counter==0 at an edge: capture alu_result/flags into rsp_* and go to RESP.
  - Else decrement the counter.
  - cmd_valid is ignored.
- RESP:
  - rsp_* held stable while rsp_ready==0.
  - On rsp_ready at an edge: op_count += 1 (wraps 2^NUMBITS-1 -> 0) and go to IDLE.
  - rsp_* keep their values after the handshake until the next capture.
- Latency: command accepted at edge E0 -> rsp_valid high after edge E(SETTLE+1).
- Throughput: one command per SETTLE+3 cycles with rsp_ready held high.
- cmd_ready is low in EXEC and RESP; no overlap of commands.
- ovf_sticky:
  - Set at the capture edge if alu_overflow==1.
  - clr_sticky==1 clears it at the edge.
  - Simultaneous set and clear: set wins.
- Flags are captured verbatim; no reinterpretation by opcode.
- All arithmetic in the stage is unsigned modulo its width.
- X/unknown on cmd_* while cmd_valid==0 must not propagate into registers.

Test Plan:
- SETTLE=0, cmd {000, A=0xFFFF, B=0x0001}, rsp_ready=1 -> rsp_valid after 2nd edge from accept; rsp_result=0x0000, carryout=1, zero=1; op_count=1 after handshake.
- Cmd {001, A=0x7FFF, B=0x0001} -> rsp_result=0x8000, overflow=1, ovf_sticky=1. Then clr_sticky pulsed the same cycle as a new overflow capture -> ovf_sticky stays 1; pulse alone -> 0.
- Backpressure: cmd {110, 0x00FF, 0x0F0F}, rsp_ready low 5 cycles -> rsp_valid=1 and rsp_result=0x0FF0 stable throughout; cmd_ready=0 despite cmd_valid=1; accepted only after handshake + IDLE.
- SETTLE=3: accept at E0 -> rsp_valid rises after E4; alu_a/alu_b/alu_opcode constant E1..E4.
- Assert reset low during EXEC -> rsp_valid=0, all outputs 0 immediately (asynchronous); after release cmd_ready=1 and no stale response ever appears.
- Preload via 0xFFFF completed handshakes (or force), one more handshake -> op_count wraps to 0x0000.
